// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_defs (package)
// Purpose  : ALU opcode constants, immediate op codes, issue FSM states and
//            decode helpers shared by the ALU issue stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_defs;

  // 8-bit ALU opcodes as presented on alu_opcode
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // 4-bit major ops
  localparam logic [3:0] IOP_REG0  = 4'h0;
  localparam logic [3:0] IOP_REG8  = 4'h8;
  localparam logic [3:0] IOP_ANDI  = 4'h1;
  localparam logic [3:0] IOP_ORI   = 4'h2;
  localparam logic [3:0] IOP_XORI  = 4'h3;
  localparam logic [3:0] IOP_ADDI  = 4'h5;
  localparam logic [3:0] IOP_ADDUI = 4'h6;
  localparam logic [3:0] IOP_SUBI  = 4'h9;
  localparam logic [3:0] IOP_CMPI  = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  // Result of decoding one instruction
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        legal;
    logic        wb;
  } dec_t;

  function automatic logic is_shift(input logic [7:0] opcode);
    return (opcode == OP_LSH) || (opcode == OP_RSH) ||
           (opcode == OP_ALSH) || (opcode == OP_ARSH);
  endfunction

  function automatic logic is_reg_legal(input logic [7:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_ADDU) || (opcode == OP_ADDC) ||
           (opcode == OP_SUB) || (opcode == OP_CMP)  || (opcode == OP_AND)  ||
           (opcode == OP_OR)  || (opcode == OP_XOR)  || (opcode == OP_NOT)  ||
           is_shift(opcode);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Purpose  : Instruction handshake, ALU operand/result and debug signals of
//            the ALU issue stage. slave = issue stage, master = environment.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_r1;
  logic [15:0] alu_r2;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_rout;
  logic        done;
  logic        illegal;
  logic [15:0] result;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  modport master (
    output instr, instr_valid, alu_rout, dbg_addr,
    input  instr_ready, alu_r1, alu_r2, alu_opcode, done, illegal, result, dbg_data
  );

  modport slave (
    input  instr, instr_valid, alu_rout, dbg_addr,
    output instr_ready, alu_r1, alu_r2, alu_opcode, done, illegal, result, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile16x16
// Purpose  : 16 x 16-bit register file, one synchronous write port, two
//            combinational operand read ports and one debug read port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile16x16 #(
  parameter int NREGS = 16
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        i_we,
  input  wire logic [3:0]  i_waddr,
  input  wire logic [15:0] i_wdata,
  input  wire logic [3:0]  i_ra_addr,
  output      logic [15:0] o_ra_data,
  input  wire logic [3:0]  i_rb_addr,
  output      logic [15:0] o_rb_data,
  input  wire logic [3:0]  i_dbg_addr,
  output      logic [15:0] o_dbg_data
);

  logic [15:0] r_mem [NREGS];

  // Reset clears every register; otherwise a single write per cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Accepts 16-bit instructions, decodes them, drives registered
//            operands to an external combinational ALU and writes the ALU
//            result back. IDLE -> DECODE -> EXEC, one instruction per 3 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int NREGS = 16
) (
  input wire logic          clk,
  input wire logic          reset_n,
  alu_issue_stage_if.slave  bus
);

  state_t      r_state;
  logic [15:0] r_instr;
  logic [15:0] r_alu_r1;
  logic [15:0] r_alu_r2;
  logic [7:0]  r_alu_opcode;
  logic [15:0] r_result;
  logic        r_done;
  logic        r_illegal;
  logic        r_legal;
  logic        r_wb;

  logic [15:0] w_rd_val;
  logic [15:0] w_rs_val;
  logic [15:0] w_dbg_data;
  logic        w_we;
  dec_t        w_dec;

  // Decode: opcode, legality, writeback enable and operand routing
  function automatic dec_t decode(input logic [15:0] ins,
                                  input logic [15:0] rd_val,
                                  input logic [15:0] rs_val);
    dec_t        d;
    logic [3:0]  op;
    logic [7:0]  opc;
    logic [15:0] src;
    op    = ins[15:12];
    opc   = 8'h00;
    src   = rs_val;
    d     = '0;
    d.r1  = rd_val;
    d.r2  = rs_val;
    case (op)
      IOP_REG0, IOP_REG8: begin
        opc     = {op, ins[7:4]};
        d.legal = is_reg_legal(opc);
      end
      IOP_ADDI, IOP_ADDUI, IOP_SUBI, IOP_CMPI: begin
        opc     = {4'h0, op};
        src     = {{8{ins[7]}}, ins[7:0]};
        d.legal = 1'b1;
      end
      IOP_ANDI, IOP_ORI, IOP_XORI: begin
        opc     = {4'h0, op};
        src     = {8'h00, ins[7:0]};
        d.legal = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    if (d.legal) begin
      d.opcode = opc;
      d.wb     = (opc != OP_CMP);
      if (is_shift(opc)) begin
        d.r1 = src;
        d.r2 = rd_val;
      end else if (opc == OP_NOT) begin
        d.r1 = src;
        d.r2 = 16'h0000;
      end else begin
        d.r1 = rd_val;
        d.r2 = src;
      end
    end
    return d;
  endfunction

  regfile16x16 #(.NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_we),
    .i_waddr    (r_instr[11:8]),
    .i_wdata    (bus.alu_rout),
    .i_ra_addr  (r_instr[11:8]),
    .o_ra_data  (w_rd_val),
    .i_rb_addr  (r_instr[3:0]),
    .o_rb_data  (w_rs_val),
    .i_dbg_addr (bus.dbg_addr),
    .o_dbg_data (w_dbg_data)
  );

  assign w_dec = decode(r_instr, w_rd_val, w_rs_val);
  assign w_we  = (r_state == S_EXEC) && r_wb;

  // Issue FSM with registered ALU operands and retirement outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_alu_r1     <= '0;
      r_alu_r2     <= '0;
      r_alu_opcode <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
      r_legal      <= 1'b0;
      r_wb         <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_alu_r1     <= w_dec.r1;
          r_alu_r2     <= w_dec.r2;
          r_alu_opcode <= w_dec.opcode;
          r_legal      <= w_dec.legal;
          r_wb         <= w_dec.wb;
          r_state      <= S_EXEC;
        end
        S_EXEC: begin
          r_done    <= 1'b1;
          r_illegal <= !r_legal;
          if (r_legal) r_result <= bus.alu_rout;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.alu_r1      = r_alu_r1;
  assign bus.alu_r2      = r_alu_r2;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;
  assign bus.result      = r_result;
  assign bus.dbg_data    = w_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed bench for alu_issue_stage with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
  import alu_defs::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage_if u_if ();

  alu_issue_stage #(.NREGS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  // Behavioural ALU placed downstream of the stage
  always_comb begin
    u_if.alu_rout = 16'h0000;
    case (u_if.alu_opcode)
      OP_ADD, OP_ADDU, OP_ADDC: u_if.alu_rout = u_if.alu_r1 + u_if.alu_r2;
      OP_SUB, OP_CMP:           u_if.alu_rout = u_if.alu_r1 - u_if.alu_r2;
      OP_AND:                   u_if.alu_rout = u_if.alu_r1 & u_if.alu_r2;
      OP_OR:                    u_if.alu_rout = u_if.alu_r1 | u_if.alu_r2;
      OP_XOR:                   u_if.alu_rout = u_if.alu_r1 ^ u_if.alu_r2;
      OP_NOT:                   u_if.alu_rout = ~u_if.alu_r1;
      OP_LSH, OP_ALSH:          u_if.alu_rout = u_if.alu_r2 << u_if.alu_r1[3:0];
      OP_RSH:                   u_if.alu_rout = u_if.alu_r2 >> u_if.alu_r1[3:0];
      OP_ARSH:                  u_if.alu_rout = 16'($signed(u_if.alu_r2) >>> u_if.alu_r1[3:0]);
      default:                  u_if.alu_rout = 16'h0000;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input logic [3:0] addr, input logic [15:0] exp);
    u_if.dbg_addr = addr;
    #1;
    chk($sformatf("R%0d", addr), u_if.dbg_data, exp);
  endtask

  // Accept one instruction at the next possible edge; lat counts falling
  // edges from the accept edge until done is seen
  task automatic issue(input logic [15:0] ins, output int lat);
    int w;
    w = 0;
    while (!u_if.instr_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!u_if.instr_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got 0, want 1");
    end
    u_if.instr       = ins;
    u_if.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.instr_valid = 1'b0;
    u_if.instr       = 16'hDEAD;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!u_if.done && lat < 10);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        ill;
    logic        chk_ops;
    logic [7:0]  op;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] res;
    logic [3:0]  addr;
    logic [15:0] rval;
  } vec_t;

  vec_t vecs [26];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    //               instr     ill   ops   op     r1        r2        res       addr  rval
    vecs[0]  = '{16'h5105, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0005, 16'h0005, 4'd1,  16'h0005};
    vecs[1]  = '{16'h0151, 1'b0, 1'b1, 8'h05, 16'h0005, 16'h0005, 16'h000A, 4'd1,  16'h000A};
    vecs[2]  = '{16'h52FF, 1'b0, 1'b1, 8'h05, 16'h0000, 16'hFFFF, 16'hFFFF, 4'd2,  16'hFFFF};
    vecs[3]  = '{16'h12FF, 1'b0, 1'b1, 8'h01, 16'hFFFF, 16'h00FF, 16'h00FF, 4'd2,  16'h00FF};
    vecs[4]  = '{16'h5301, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0001, 16'h0001, 4'd3,  16'h0001};
    vecs[5]  = '{16'h5404, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0004, 16'h0004, 4'd4,  16'h0004};
    vecs[6]  = '{16'h8344, 1'b0, 1'b1, 8'h84, 16'h0004, 16'h0001, 16'h0010, 4'd3,  16'h0010};
    vecs[7]  = '{16'h5507, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0007, 16'h0007, 4'd5,  16'h0007};
    vecs[8]  = '{16'h5607, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0007, 16'h0007, 4'd6,  16'h0007};
    vecs[9]  = '{16'h05B6, 1'b0, 1'b1, 8'h0B, 16'h0007, 16'h0007, 16'h0000, 4'd5,  16'h0007};
    vecs[10] = '{16'hF000, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 4'd0,  16'h0000};
    vecs[11] = '{16'h0195, 1'b0, 1'b1, 8'h09, 16'h000A, 16'h0007, 16'h0003, 4'd1,  16'h0003};
    vecs[12] = '{16'h0644, 1'b0, 1'b1, 8'h04, 16'h0004, 16'h0000, 16'hFFFB, 4'd6,  16'hFFFB};
    vecs[13] = '{16'h2780, 1'b0, 1'b1, 8'h02, 16'h0000, 16'h0080, 16'h0080, 4'd7,  16'h0080};
    vecs[14] = '{16'h06F4, 1'b0, 1'b1, 8'h0F, 16'h0004, 16'hFFFB, 16'hFFFF, 4'd6,  16'hFFFF};
    vecs[15] = '{16'h0784, 1'b0, 1'b1, 8'h08, 16'h0004, 16'h0080, 16'h0008, 4'd7,  16'h0008};
    vecs[16] = '{16'h98FE, 1'b0, 1'b1, 8'h09, 16'h0000, 16'hFFFE, 16'h0002, 4'd8,  16'h0002};
    vecs[17] = '{16'h01A1, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0002, 4'd1,  16'h0003};
    vecs[18] = '{16'h8100, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0002, 4'd1,  16'h0003};
    vecs[19] = '{16'h3803, 1'b0, 1'b1, 8'h03, 16'h0002, 16'h0003, 16'h0001, 4'd8,  16'h0001};
    vecs[20] = '{16'h08C4, 1'b0, 1'b1, 8'h0C, 16'h0004, 16'h0001, 16'h0010, 4'd8,  16'h0010};
    vecs[21] = '{16'hB105, 1'b0, 1'b1, 8'h0B, 16'h0003, 16'h0005, 16'hFFFE, 4'd1,  16'h0003};
    vecs[22] = '{16'h69FF, 1'b0, 1'b1, 8'h06, 16'h0000, 16'hFFFF, 16'hFFFF, 4'd9,  16'hFFFF};
    vecs[23] = '{16'h0971, 1'b0, 1'b1, 8'h07, 16'hFFFF, 16'h0003, 16'h0002, 4'd9,  16'h0002};
    vecs[24] = '{16'h0021, 1'b0, 1'b1, 8'h02, 16'h0000, 16'h0003, 16'h0003, 4'd0,  16'h0003};
    vecs[25] = '{16'h7000, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0003, 4'd0,  16'h0003};

    u_if.instr       = 16'h0000;
    u_if.instr_valid = 1'b0;
    u_if.dbg_addr    = 4'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",   16'(u_if.instr_ready), 16'h0001);
    chk("rst_done",    16'(u_if.done),        16'h0000);
    chk("rst_illegal", 16'(u_if.illegal),     16'h0000);
    chk("rst_result",  u_if.result,           16'h0000);
    chk("rst_r1",      u_if.alu_r1,           16'h0000);
    chk("rst_r2",      u_if.alu_r2,           16'h0000);
    chk("rst_opcode",  16'(u_if.alu_opcode),  16'h0000);
    for (int i = 0; i < 16; i++) chk_reg(4'(i), 16'h0000);

    // Table of directed instructions, issued back to back
    for (int i = 0; i < 26; i++) begin
      issue(vecs[i].instr, lat);
      chk($sformatf("v%0d_latency", i), 16'(lat), 16'd3);
      chk($sformatf("v%0d_done", i), 16'(u_if.done), 16'h0001);
      chk($sformatf("v%0d_illegal", i), 16'(u_if.illegal), 16'(vecs[i].ill));
      chk($sformatf("v%0d_result", i), u_if.result, vecs[i].res);
      chk($sformatf("v%0d_opcode", i), 16'(u_if.alu_opcode), 16'(vecs[i].op));
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d_alu_r1", i), u_if.alu_r1, vecs[i].r1);
        chk($sformatf("v%0d_alu_r2", i), u_if.alu_r2, vecs[i].r2);
      end
      chk_reg(vecs[i].addr, vecs[i].rval);
    end

    // CMP: done is a single pulse, result held, no writeback
    issue(16'h05B6, lat);
    chk("cmp2_result", u_if.result, 16'h0008);
    @(negedge clk);
    chk("cmp2_done_pulse", 16'(u_if.done), 16'h0000);
    chk("cmp2_result_hold", u_if.result, 16'h0008);
    chk_reg(4'd5, 16'h0007);

    // instr_valid held and instr changed after acceptance are ignored
    u_if.instr       = 16'h5A01;
    u_if.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.instr = 16'h5A7F;
    @(negedge clk);
    chk("hold_ready_dec", 16'(u_if.instr_ready), 16'h0000);
    @(negedge clk);
    chk("hold_ready_exec", 16'(u_if.instr_ready), 16'h0000);
    @(negedge clk);
    chk("hold_done", 16'(u_if.done), 16'h0001);
    u_if.instr_valid = 1'b0;
    chk("hold_result", u_if.result, 16'h0001);
    chk_reg(4'd10, 16'h0001);
    @(negedge clk);

    // Reset asserted during EXEC of ADD R1,R1
    u_if.instr       = 16'h0151;
    u_if.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_done", 16'(u_if.done), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready",  16'(u_if.instr_ready), 16'h0001);
    chk("rx_done2",  16'(u_if.done),        16'h0000);
    chk("rx_result", u_if.result,           16'h0000);
    chk("rx_opcode", 16'(u_if.alu_opcode),  16'h0000);
    for (int i = 0; i < 16; i++) chk_reg(4'(i), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
